acorn_decryption: RTL and testbench

Bit-serial ACORN-128 decryption for a single 128-bit ciphertext block. Starting from the 293-bit state left by initialization/associated-data processing, it recovers plaintext one bit per cycle (P_i = C_i xor ks_i), feeds each recovered bit back as the message bit of the state update, then runs the 256-step padding phase. The final state is handed to the finalization/tag stage. It is the receive-side counterpart of the encryption stage and reuses the same `state_update128` and `ksg128` cores.

---
 rtl/acorn_decryption_if.sv | 21 ++
 rtl/acorn_decryption.sv | 158 +++++++++++++++
 tb/tb_acorn_decryption.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acorn_decryption_if.sv
// acorn_decryption_if: request/result bundle for the ACORN-128 decryption stage.
// master drives start/state_in/cipher_in; slave returns busy/done/plain_out/state_out.
interface acorn_decryption_if;
  logic         start;
  logic [292:0] state_in;
  logic [127:0] cipher_in;
  logic         busy;
  logic         done;
  logic [127:0] plain_out;
  logic [292:0] state_out;

  modport master (
    output start, state_in, cipher_in,
    input  busy, done, plain_out, state_out
  );

  modport slave (
    input  start, state_in, cipher_in,
    output busy, done, plain_out, state_out
  );
endinterface

// File: rtl/acorn_decryption.sv
// acorn_decryption: bit-serial ACORN-128 decryption of one block plus padding.
// ports: clk, rst (async, active-high), bus (acorn_decryption_if.slave).
module ksg128 (
  input  logic [292:0] s,
  output logic         ks
);
  logic s61, s154, s193, s230;
  logic maj_t, ch_t;

  // keystream uses the linear-feedback-updated taps of the current state
  assign s61  = s[61]  ^ s[23]  ^ s[0];
  assign s154 = s[154] ^ s[111] ^ s[107];
  assign s193 = s[193] ^ s[160] ^ s[154];
  assign s230 = s[230] ^ s[196] ^ s[193];

  assign maj_t = (s[235] & s61) ^ (s[235] & s193)
               ^ (s61 & s193);
  assign ch_t  = (s230 & s[111]) ^ (~s230 & s[66]);
  assign ks    = s[12] ^ s154 ^ maj_t ^ ch_t;
endmodule

module state_update128 (
  input  logic [292:0] s,
  input  logic         ca,
  input  logic         cb,
  input  logic         mbit,
  input  logic         ks,
  output logic [292:0] s_nxt
);
  logic [292:0] t;
  logic         maj_f;
  logic         f;

  always_comb begin
    t      = s;
    t[289] = s[289] ^ s[235] ^ s[230];
    t[230] = s[230] ^ s[196] ^ s[193];
    t[193] = s[193] ^ s[160] ^ s[154];
    t[154] = s[154] ^ s[111] ^ s[107];
    t[107] = s[107] ^ s[66]  ^ s[61];
    t[61]  = s[61]  ^ s[23]  ^ s[0];
    maj_f  = (t[244] & t[23]) ^ (t[244] & t[160])
           ^ (t[23] & t[160]);
    f      = t[0] ^ ~t[107] ^ maj_f
           ^ (ca & t[196]) ^ (cb & ks) ^ mbit;
    s_nxt  = {f, t[292:1]};
  end
endmodule

module acorn_decryption #(
  parameter int PLEN   = 128,
  parameter int PADLEN = 256
) (
  input logic          clk,
  input logic          rst,
  acorn_decryption_if.slave bus
);
  localparam int KW = $clog2(PLEN);

  typedef enum logic [1:0] {
    IDLE, DEC, PAD, FIN
  } st_t;

  st_t          st_q, st_d;
  logic [8:0]   k_q;
  logic [292:0] s_q;
  logic [292:0] so_q;
  logic [127:0] c_q;
  logic [127:0] p_q;

  logic         ks;
  logic         ca, cb, mbit;
  logic [292:0] s_nxt;
  logic [KW-1:0] idx;
  logic         dec_last, pad_last;

  assign idx      = k_q[KW-1:0];
  assign dec_last = (k_q == 9'(PLEN - 1));
  assign pad_last = (k_q == 9'(PADLEN - 1));

  ksg128 u_ksg (
    .s  (s_q),
    .ks (ks)
  );

  state_update128 u_upd (
    .s     (s_q),
    .ca    (ca),
    .cb    (cb),
    .mbit  (mbit),
    .ks    (ks),
    .s_nxt (s_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    ca   = 1'b0;
    cb   = 1'b0;
    mbit = 1'b0;
    unique case (st_q)
      IDLE: if (bus.start) st_d = DEC;
      DEC: begin
        ca   = 1'b1;
        mbit = c_q[idx] ^ ks;
        if (dec_last) st_d = PAD;
      end
      PAD: begin
        ca   = (k_q < 9'(PADLEN / 2));
        mbit = (k_q == 9'd0);
        if (pad_last) st_d = FIN;
      end
      FIN: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q  <= '0;
      s_q  <= '0;
      so_q <= '0;
      c_q  <= '0;
      p_q  <= '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (bus.start) begin
            s_q <= bus.state_in;
            c_q <= bus.cipher_in;
            k_q <= '0;
          end
        end
        DEC: begin
          p_q[idx] <= mbit;
          s_q      <= s_nxt;
          k_q      <= dec_last ? 9'd0 : k_q + 9'd1;
        end
        PAD: begin
          s_q <= s_nxt;
          k_q <= pad_last ? 9'd0 : k_q + 9'd1;
          if (pad_last) so_q <= s_nxt;
        end
        FIN: ;
        default: ;
      endcase
    end
  end

  assign bus.busy      = (st_q != IDLE);
  assign bus.done      = (st_q == FIN);
  assign bus.plain_out = p_q;
  assign bus.state_out = so_q;
endmodule

// File: tb/tb_acorn_decryption.sv
// tb_acorn_decryption: scoreboard bench for acorn_decryption.
// stimulus pushes expected plaintext/state; a monitor checks on done.
module tb_acorn_decryption;
  logic clk = 1'b0;
  logic rst;
  int   cyc  = 0;
  int   vec  = 0;
  int   errs = 0;

  acorn_decryption_if bus();

  acorn_decryption dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [127:0] p;
    logic [292:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   t_q[$];

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic logic [292:0] lin(logic [292:0] s);
    logic [292:0] t;
    t = s;
    t[289] = t[289] ^ t[235] ^ t[230];
    t[230] = t[230] ^ t[196] ^ t[193];
    t[193] = t[193] ^ t[160] ^ t[154];
    t[154] = t[154] ^ t[111] ^ t[107];
    t[107] = t[107] ^ t[66]  ^ t[61];
    t[61]  = t[61]  ^ t[23]  ^ t[0];
    return t;
  endfunction

  function automatic logic mj(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic ks_of(logic [292:0] s);
    logic [292:0] t;
    logic ch;
    t  = lin(s);
    ch = t[230] ? t[111] : t[66];
    return t[12] ^ t[154] ^ mj(t[235], t[61], t[193]) ^ ch;
  endfunction

  function automatic logic [292:0] step(
    logic [292:0] s, logic ca, logic cb, logic m);
    logic [292:0] t;
    logic f;
    t = lin(s);
    f = t[0] ^ ~t[107] ^ mj(t[244], t[23], t[160]);
    f = f ^ (ca & t[196]) ^ (cb & ks_of(s)) ^ m;
    for (int j = 0; j < 292; j++) t[j] = t[j+1];
    t[292] = f;
    return t;
  endfunction

  function automatic logic [292:0] pad(logic [292:0] s);
    for (int k = 0; k < 256; k++)
      s = step(s, k < 128, 1'b0, k == 0);
    return s;
  endfunction

  task automatic enc(input logic [292:0] s0,
    input logic [127:0] p,
    output logic [127:0] c, output logic [292:0] sf);
    logic [292:0] s;
    s = s0;
    for (int i = 0; i < 128; i++) begin
      c[i] = p[i] ^ ks_of(s);
      s = step(s, 1'b1, 1'b0, p[i]);
    end
    sf = pad(s);
  endtask

  task automatic dec(input logic [292:0] s0,
    input logic [127:0] c,
    output logic [127:0] p, output logic [292:0] sf);
    logic [292:0] s;
    s = s0;
    for (int i = 0; i < 128; i++) begin
      p[i] = c[i] ^ ks_of(s);
      s = step(s, 1'b1, 1'b0, p[i]);
    end
    sf = pad(s);
  endtask

  task automatic chk(string nm, logic [292:0] act,
    logic [292:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    int   t0;
    logic bp, dp;
    bp = 1'b0;
    dp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        t_q.delete();
        bp = 1'b0;
        dp = 1'b0;
      end else begin
        if (bus.busy && !bp) t_q.push_back(cyc);
        if (bus.done) begin
          chk("done_width", 293'(dp), 293'(0));
          chk("done_expected", 293'(exp_q.size() > 0), 293'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("plain_out", 293'(bus.plain_out), 293'(e.p));
            chk("state_out", bus.state_out, e.s);
          end
          t0 = (t_q.size() > 0) ? t_q.pop_front() : -1000;
          chk("e0_to_done_edges", 293'(cyc - t0), 293'(384));
        end
        bp = bus.busy;
        dp = bus.done;
      end
    end
  end

  task automatic issue(input logic [292:0] s,
    input logic [127:0] c, input logic [127:0] ep,
    input logic [292:0] es, input bit push);
    bus.start     = 1'b1;
    bus.state_in  = s;
    bus.cipher_in = c;
    if (push) exp_q.push_back('{p: ep, s: es});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    while (!bus.done && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", 293'(n < 600), 293'(1));
    t = cyc;
  endtask

  initial begin
    logic [292:0] sa, sb, sf_a, sf_z, sf_0, sf_1, sf_b;
    logic [127:0] pa, pb, ca, cb, pz, p0, ones;
    int t, ta, tb;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.state_in  = '0;
    bus.cipher_in = '0;
    ones          = '1;

    sa = {5'h15, 32'hDEADBEEF, 32'h0BADF00D, 32'hCAFEBABE,
          32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C,
          32'h4B5A6978, 32'h87968574, 32'hA5C3E1F7};
    sb = {5'h0A, 32'h13579BDF, 32'h2468ACE0, 32'hFFFF0000,
          32'h00FF00FF, 32'h5A5A5A5A, 32'hC3C3C3C3,
          32'h01020304, 32'hF0E0D0C0, 32'h7E7E7E7E};
    pa = 128'h0123456789ABCDEF_FEDCBA9876543210;
    pb = 128'hA5A5A5A5_00000000_FFFFFFFF_3C3C3C3C;
    enc(sa, pa, ca, sf_a);
    enc(sb, pb, cb, sf_b);
    dec(sa, '0, pz, sf_z);
    dec('0, '0, p0, sf_0);
    dec('0, ones, p0, sf_1);
    dec('0, '0, p0, sf_0);

    repeat (3) @(negedge clk);
    chk("rst_busy", 293'(bus.busy), 293'(0));
    chk("rst_done", 293'(bus.done), 293'(0));
    chk("rst_plain", 293'(bus.plain_out), 293'(0));
    chk("rst_state", bus.state_out, 293'(0));
    rst = 1'b0;
    @(negedge clk);

    // round trip
    issue(sa, ca, pa, sf_a, 1'b1);
    wait_done(t);
    @(negedge clk);

    // ciphertext zero: plaintext is the raw keystream
    issue(sa, '0, pz, sf_z, 1'b1);
    wait_done(t);
    @(negedge clk);

    // zero state, zero ciphertext: low keystream is zero
    issue('0, '0, p0, sf_0, 1'b1);
    wait_done(t);
    chk("zero_low64", 293'(bus.plain_out[63:0]), 293'(0));
    @(negedge clk);

    // zero state, all-ones ciphertext keeps state at zero
    issue('0, ones, ones, sf_1, 1'b1);
    wait_done(t);
    @(negedge clk);

    // start while busy, in DEC and in FIN
    issue(sa, ca, pa, sf_a, 1'b1);
    repeat (48) @(negedge clk);
    bus.start     = 1'b1;
    bus.state_in  = sb;
    bus.cipher_in = cb;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(t);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("fin_start_ignored", 293'(bus.busy), 293'(0));

    // reset mid-operation
    issue(sb, cb, pb, sf_b, 1'b0);
    repeat (198) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 293'(bus.busy), 293'(0));
    chk("abort_plain", 293'(bus.plain_out), 293'(0));
    chk("abort_state", bus.state_out, 293'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(sa, ca, pa, sf_a, 1'b1);
    wait_done(t);

    // back-to-back: start held across FIN, taken in IDLE
    ta = t;
    bus.start     = 1'b1;
    bus.state_in  = sb;
    bus.cipher_in = cb;
    exp_q.push_back('{p: pb, s: sf_b});
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("plain_hold", 293'(bus.plain_out), 293'(pa));
    wait_done(tb);
    chk("done_spacing", 293'(tb - ta), 293'(386));

    repeat (5) @(negedge clk);
    chk("queue_empty", 293'(exp_q.size()), 293'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end
endmodule
